// File: rtl/gol_pkg.sv
// Shared VGA timing defaults, the pipeline stage type and the line/frame total helper
// for the Game-of-Life scanout.
package gol_pkg;

  localparam int unsigned H_ACT_DEF = 640;
  localparam int unsigned H_FP_DEF  = 16;
  localparam int unsigned H_SYN_DEF = 96;
  localparam int unsigned H_BP_DEF  = 48;
  localparam int unsigned V_ACT_DEF = 480;
  localparam int unsigned V_FP_DEF  = 10;
  localparam int unsigned V_SYN_DEF = 2;
  localparam int unsigned V_BP_DEF  = 33;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

  // Total period (H_TOT or V_TOT) from its four timing segments.
  function automatic int unsigned timing_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned syn, input int unsigned bp);
    return act + fp + syn + bp;
  endfunction

  localparam int unsigned H_TOT_DEF = timing_total(H_ACT_DEF, H_FP_DEF, H_SYN_DEF, H_BP_DEF);
  localparam int unsigned V_TOT_DEF = timing_total(V_ACT_DEF, V_FP_DEF, V_SYN_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_counter.sv
// Pixel-clock divider plus horizontal/vertical raster counters with a frame-origin pulse.
module vga_counter
  import gol_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned H_TOT   = H_TOT_DEF,
  parameter int unsigned V_TOT   = V_TOT_DEF
)(
  input  logic       clk,
  input  logic       rst_b,
  output logic       pix_tick,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       frame_start
);

  logic h_last;
  logic v_last;

  generate
    if (CLK_DIV <= 1) begin : g_nodiv
      assign pix_tick = 1'b1;
    end else begin : g_div
      localparam int unsigned DW = $clog2(CLK_DIV);
      logic [DW-1:0] div;

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          div <= '0;
        end else if (div == DW'(CLK_DIV - 1)) begin
          div <= '0;
        end else begin
          div <= div + 1'b1;
        end
      end

      assign pix_tick = (div == DW'(CLK_DIV - 1));
    end
  endgenerate

  assign h_last = (hcnt == 10'(H_TOT - 1));
  assign v_last = (vcnt == 10'(V_TOT - 1));

  // frame_start marks a genuine wrap only; the reset-forced (0,0) never pulses.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && h_last && v_last;
      if (pix_tick) begin
        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gol_vga_scanout.sv
// VGA scanout: raster counters, sync/blank delay line matching the object latency,
// and the object/background/blank colour mux.
module gol_vga_scanout
  import gol_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned OBJ_LAT = 2,
  parameter int unsigned H_ACT   = H_ACT_DEF,
  parameter int unsigned H_FP    = H_FP_DEF,
  parameter int unsigned H_SYN   = H_SYN_DEF,
  parameter int unsigned H_BP    = H_BP_DEF,
  parameter int unsigned V_ACT   = V_ACT_DEF,
  parameter int unsigned V_FP    = V_FP_DEF,
  parameter int unsigned V_SYN   = V_SYN_DEF,
  parameter int unsigned V_BP    = V_BP_DEF,
  parameter logic [23:0] BG_RGB  = 24'h000040
)(
  input  logic        clk,
  input  logic        rst_b,
  input  logic [23:0] gol_rgb,
  input  logic        gol_gfx_en,
  output logic [9:0]  abs_ptrR,
  output logic [9:0]  abs_ptrC,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  logic        pix_tick;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  sync_t       raw;
  sync_t       dly;
  logic [23:0] rgb;

  vga_counter #(
    .CLK_DIV (CLK_DIV),
    .H_TOT   (timing_total(H_ACT, H_FP, H_SYN, H_BP)),
    .V_TOT   (timing_total(V_ACT, V_FP, V_SYN, V_BP))
  ) u_counter (
    .clk         (clk),
    .rst_b       (rst_b),
    .pix_tick    (pix_tick),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .frame_start (frame_start)
  );

  assign abs_ptrC = hcnt;
  assign abs_ptrR = vcnt;

  always_comb begin
    raw     = SYNC_IDLE;
    raw.act = (hcnt < 10'(H_ACT)) && (vcnt < 10'(V_ACT));
    raw.hs  = !((hcnt >= 10'(H_ACT + H_FP)) && (hcnt < 10'(H_ACT + H_FP + H_SYN)));
    raw.vs  = !((vcnt >= 10'(V_ACT + V_FP)) && (vcnt < 10'(V_ACT + V_FP + V_SYN)));
  end

  // Delay matches the object pipeline so sync, blank and colour stay aligned.
  generate
    if (OBJ_LAT == 0) begin : g_nodly
      assign dly = raw;
    end else begin : g_dly
      sync_t stage [OBJ_LAT];

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          for (int unsigned i = 0; i < OBJ_LAT; i++) stage[i] <= SYNC_IDLE;
        end else if (pix_tick) begin
          stage[0] <= raw;
          for (int unsigned i = 1; i < OBJ_LAT; i++) stage[i] <= stage[i-1];
        end
      end

      assign dly = stage[OBJ_LAT-1];
    end
  endgenerate

  // Object inputs are consulted only inside the delayed active window.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      rgb         <= '0;
    end else if (pix_tick) begin
      vga_hs      <= dly.hs;
      vga_vs      <= dly.vs;
      vga_blank_n <= dly.act;
      if (!dly.act) begin
        rgb <= '0;
      end else if (gol_gfx_en) begin
        rgb <= gol_rgb;
      end else begin
        rgb <= BG_RGB;
      end
    end
  end

  assign vga_r = rgb[23:16];
  assign vga_g = rgb[15:8];
  assign vga_b = rgb[7:0];

endmodule
